shift_unit_pipe: RTL and testbench

SHIFT_UNIT_PIPE -- requirements
Module: shift_unit_pipe

---
 rtl/shift_unit_pipe_if.sv | 38 +++
 rtl/shift_unit_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_shift_unit_pipe.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_pipe_if.sv
// ----------------------------------------------------------------------------
// shift_unit_pipe_if
// Handshake and data bundle for the pipelined shift unit.
//
//   in_valid / in_ready   : operand transfer, upstream -> shifter
//   data_in               : signed operand
//   shift_amount          : unsigned shift count
//   mode                  : 00 asr, 01 lsr, 10 asr rounded, 11 lsl saturating
//   out_valid / out_ready : result transfer, shifter -> downstream
//   data_out, sat_flag    : signed result and clamp indication
//
// master : the environment driving operands and consuming results
// slave  : the shift unit itself
// ----------------------------------------------------------------------------
interface shift_unit_pipe_if #(
  parameter int WORD_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_WIDTH-1:0]  data_in;
  logic [SHIFT_WIDTH-1:0] shift_amount;
  logic [1:0]             mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_WIDTH-1:0]  data_out;
  logic                   sat_flag;

  modport master (
    output in_valid, data_in, shift_amount, mode, out_ready,
    input  in_ready, out_valid, data_out, sat_flag
  );

  modport slave (
    input  in_valid, data_in, shift_amount, mode, out_ready,
    output in_ready, out_valid, data_out, sat_flag
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// ----------------------------------------------------------------------------
// shift_unit_pipe
// Pipelined barrel shifter with four modes (arithmetic right, logical right,
// arithmetic right with round-half-up, saturating left). One shift stage per
// bit of shift_amount (LSB first, stage k shifts by 2^k), followed by one
// output stage that applies rounding or saturation. Latency SHIFT_WIDTH+1.
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : shift_unit_pipe_if.slave (operand in, result out, handshakes)
//
// Flow control is a single global advance: every stage loads when the output
// register is empty or being consumed, and everything holds otherwise. Bubbles
// travel through the pipe like operands and are never squeezed out.
// ----------------------------------------------------------------------------
module shift_unit_pipe #(
  parameter int WORD_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  shift_unit_pipe_if.slave bus
);

  localparam int WW = WORD_WIDTH;
  localparam int SW = SHIFT_WIDTH;

  localparam logic [1:0] MODE_ASR  = 2'b00;
  localparam logic [1:0] MODE_LSR  = 2'b01;
  localparam logic [1:0] MODE_RND  = 2'b10;
  localparam logic [1:0] MODE_LSAT = 2'b11;

  localparam logic [WW-1:0] SAT_POS = {1'b0, {(WW-1){1'b1}}};
  localparam logic [WW-1:0] SAT_NEG = {1'b1, {(WW-1){1'b0}}};

  logic adv;

  logic          out_valid_q;
  logic [WW-1:0] data_out_q;
  logic          sat_flag_q;

  assign adv          = bus.out_ready | ~out_valid_q;
  assign bus.in_ready = adv;

  // --------------------------------------------------------------------------
  // Shift stages. Each stage carries:
  //   vld_q  : slot holds an operand
  //   mode_q : operation
  //   val_q  : partial result
  //   sh_q   : shift amount (stage k consumes bit k)
  //   sgn_q  : sign of the original operand (fill bit and clamp direction)
  //   grd_q  : last bit shifted out on the right so far (rounding increment)
  //   ovf_q  : sticky, some bit lost on the left differed from the sign
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int N = 2 ** k;

    logic          vld_s;
    logic [1:0]    mode_s;
    logic [WW-1:0] val_s;
    logic [SW-1:0] sh_s;
    logic          sgn_s;
    logic          grd_s;
    logic          ovf_s;

    if (k == 0) begin : g_src_in
      assign vld_s  = bus.in_valid;
      assign mode_s = bus.mode;
      assign val_s  = bus.data_in;
      assign sh_s   = bus.shift_amount;
      assign sgn_s  = bus.data_in[WW-1];
      assign grd_s  = 1'b0;
      assign ovf_s  = 1'b0;
    end else begin : g_src_prev
      assign vld_s  = g_stage[k-1].vld_q;
      assign mode_s = g_stage[k-1].mode_q;
      assign val_s  = g_stage[k-1].val_q;
      assign sh_s   = g_stage[k-1].sh_q;
      assign sgn_s  = g_stage[k-1].sgn_q;
      assign grd_s  = g_stage[k-1].grd_q;
      assign ovf_s  = g_stage[k-1].ovf_q;
    end

    logic          fill;
    logic [WW-1:0] rsh;
    logic          rgrd;
    logic [WW-1:0] lsh;
    logic          lovf;

    assign fill = (mode_s == MODE_LSR) ? 1'b0 : sgn_s;

    if (N >= WW) begin : g_wide
      // Whole word leaves: right shift collapses to fill, left shift to zero.
      // Any non-zero word loses a bit that disagrees with the final MSB.
      assign rsh  = {WW{fill}};
      assign rgrd = fill;
      assign lsh  = '0;
      assign lovf = |val_s;
    end else begin : g_narrow
      logic [2*WW-1:0] rext;
      assign rext = {{WW{fill}}, val_s} >> N;
      assign rsh  = rext[WW-1:0];
      // Bit N-1 of the current word is original bit (s_so_far-1), so the last
      // shifting stage leaves exactly the final shifted-out bit here.
      assign rgrd = val_s[N-1];
      assign lsh  = val_s << N;
      // The N bits dropped plus the new MSB must all equal the original sign.
      // Overlap with the previous stage's window is harmless.
      assign lovf = (val_s[WW-1 -: N+1] != {(N+1){sgn_s}});
    end

    logic [WW-1:0] val_d;
    logic          grd_d;
    logic          ovf_d;

    always_comb begin
      val_d = val_s;
      grd_d = grd_s;
      ovf_d = ovf_s;
      if (sh_s[k]) begin
        if (mode_s == MODE_LSAT) begin
          val_d = lsh;
          ovf_d = ovf_s | lovf;
        end else begin
          val_d = rsh;
          grd_d = rgrd;
        end
      end
    end

    logic          vld_q;
    logic [1:0]    mode_q;
    logic [WW-1:0] val_q;
    logic [SW-1:0] sh_q;
    logic          sgn_q;
    logic          grd_q;
    logic          ovf_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q  <= 1'b0;
        mode_q <= MODE_ASR;
        val_q  <= '0;
        sh_q   <= '0;
        sgn_q  <= 1'b0;
        grd_q  <= 1'b0;
        ovf_q  <= 1'b0;
      end else if (adv) begin
        vld_q  <= vld_s;
        mode_q <= mode_s;
        val_q  <= val_d;
        sh_q   <= sh_s;
        sgn_q  <= sgn_s;
        grd_q  <= grd_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output stage: rounding increment or saturation clamp.
  // Rounding cannot overflow: with s>=1 the shifted value is at most
  // 2^(WW-2)-1, and with s=0 the guard is 0.
  // --------------------------------------------------------------------------
  logic          fin_vld;
  logic [1:0]    fin_mode;
  logic [WW-1:0] fin_val;
  logic          fin_sgn;
  logic          fin_grd;
  logic          fin_ovf;

  assign fin_vld  = g_stage[SW-1].vld_q;
  assign fin_mode = g_stage[SW-1].mode_q;
  assign fin_val  = g_stage[SW-1].val_q;
  assign fin_sgn  = g_stage[SW-1].sgn_q;
  assign fin_grd  = g_stage[SW-1].grd_q;
  assign fin_ovf  = g_stage[SW-1].ovf_q;

  logic [WW-1:0] data_out_d;
  logic          sat_flag_d;

  always_comb begin
    data_out_d = fin_val;
    sat_flag_d = 1'b0;
    case (fin_mode)
      MODE_RND: begin
        data_out_d = fin_val + {{(WW-1){1'b0}}, fin_grd};
      end
      MODE_LSAT: begin
        if (fin_ovf) begin
          data_out_d = fin_sgn ? SAT_NEG : SAT_POS;
          sat_flag_d = 1'b1;
        end
      end
      default: begin
        data_out_d = fin_val;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      sat_flag_q  <= 1'b0;
    end else if (adv) begin
      out_valid_q <= fin_vld;
      data_out_q  <= data_out_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
module tb_shift_unit_pipe;

  localparam int WW  = 16;
  localparam int SW  = 4;
  localparam int LAT = SW + 1;

  logic clk;
  logic rst;

  shift_unit_pipe_if #(.WORD_WIDTH(WW), .SHIFT_WIDTH(SW)) sif ();

  shift_unit_pipe #(.WORD_WIDTH(WW), .SHIFT_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cycle      = 0;
  bit lat_chk    = 1'b0;

  typedef struct {
    logic [WW-1:0] d;
    logic          s;
    int            stamp;
    bit            lat;
  } exp_t;

  exp_t q[$];

  // Reference: the mathematical definition of each mode on signed integers.
  function automatic logic [WW:0] model(logic [WW-1:0] d, int s, logic [1:0] m);
    longint x;
    longint u;
    longint r;
    logic   sat;
    x   = longint'($signed(d));
    u   = longint'(d);
    sat = 1'b0;
    r   = 0;
    case (m)
      2'b00: r = (s >= WW) ? ((x < 0) ? -1 : 0) : (x >>> s);
      2'b01: r = (s >= WW) ? 0 : (u >> s);
      2'b10: r = (x >>> s) + ((s == 0) ? 0 : ((x >>> (s - 1)) & 1));
      default: begin
        r = x * (longint'(1) << s);
        if (r > 32767) begin
          r = 32767;
          sat = 1'b1;
        end else if (r < -32768) begin
          r = -32768;
          sat = 1'b1;
        end
      end
    endcase
    return {sat, r[WW-1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic pin_model(input logic [WW-1:0] d, input int s, input logic [1:0] m,
                           input logic [WW:0] exp);
    check($sformatf("model d=%h s=%0d m=%0d", d, s, m), 32'(model(d, s, m)), 32'(exp));
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor / scoreboard
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_d;
  logic          prev_s;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall out_valid", 32'(sif.out_valid), 32'd1);
        check("stall data_out", 32'(sif.data_out), 32'(prev_d));
        check("stall sat_flag", 32'(sif.sat_flag), 32'(prev_s));
      end
      if (sif.out_valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected result: got %h with no operand pending", sif.data_out);
        end else if (sif.out_ready) begin
          exp_t e;
          e = q.pop_front();
          check("data_out", 32'(sif.data_out), 32'(e.d));
          check("sat_flag", 32'(sif.sat_flag), 32'(e.s));
          if (e.lat) check("latency", 32'(cycle - e.stamp), 32'(LAT));
        end
      end
      prev_stall = sif.out_valid & ~sif.out_ready;
      prev_d     = sif.data_out;
      prev_s     = sif.sat_flag;
      if (sif.in_valid && sif.in_ready) begin
        exp_t n;
        logic [WW:0] r;
        r       = model(sif.data_in, int'(sif.shift_amount), sif.mode);
        n.d     = r[WW-1:0];
        n.s     = r[WW];
        n.stamp = cycle;
        n.lat   = lat_chk;
        q.push_back(n);
      end
    end
  end

  task automatic send(input logic [WW-1:0] d, input logic [SW-1:0] s, input logic [1:0] m);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    sif.in_valid     = 1'b1;
    sif.data_in      = d;
    sif.shift_amount = s;
    sif.mode         = m;
    do begin
      @(negedge clk);
      acc = sif.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL accept timeout: got in_ready 0 expected 1 within 200 cycles");
    end
    sif.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    sif.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return WW'($urandom_range(0, 15));
      1:       return WW'(16'hFFFF - $urandom_range(0, 15));
      default: return WW'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    sif.in_valid     = 1'b0;
    sif.data_in      = '0;
    sif.shift_amount = '0;
    sif.mode         = 2'b00;
    sif.out_ready    = 1'b1;
    #1;
    check("reset out_valid", 32'(sif.out_valid), 32'd0);
    check("reset data_out", 32'(sif.data_out), 32'd0);
    check("reset sat_flag", 32'(sif.sat_flag), 32'd0);
    check("reset in_ready", 32'(sif.in_ready), 32'd1);

    // Pin the reference against hand-computed values
    pin_model(16'h8000, 3, 2'b00, 17'h0F000);
    pin_model(16'h8000, 3, 2'b01, 17'h01000);
    pin_model(16'h0007, 1, 2'b10, 17'h00004);
    pin_model(16'hFFF9, 1, 2'b10, 17'h0FFFD);
    pin_model(16'h7FFF, 0, 2'b10, 17'h07FFF);
    pin_model(16'h8000, 15, 2'b10, 17'h0FFFF);
    pin_model(16'h0003, 2, 2'b11, 17'h0000C);
    pin_model(16'h4000, 1, 2'b11, 17'h17FFF);
    pin_model(16'hC000, 1, 2'b11, 17'h08000);
    pin_model(16'hA000, 2, 2'b11, 17'h18000);
    pin_model(16'h0000, 15, 2'b11, 17'h00000);
    pin_model(16'hFFFF, 15, 2'b01, 17'h00001);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed corner vectors, latency checked
    lat_chk = 1'b1;
    send(16'h8000, 4'd3, 2'b00);
    send(16'h8000, 4'd3, 2'b01);
    send(16'h0007, 4'd1, 2'b10);
    send(16'hFFF9, 4'd1, 2'b10);
    send(16'h7FFF, 4'd0, 2'b10);
    send(16'h8000, 4'd15, 2'b10);
    send(16'h0003, 4'd2, 2'b11);
    send(16'h4000, 4'd1, 2'b11);
    send(16'hC000, 4'd1, 2'b11);
    send(16'hA000, 4'd2, 2'b11);
    send(16'h0000, 4'd15, 2'b11);
    for (int m = 0; m < 4; m++) send(16'hB5A3, 4'd0, 2'(m));
    idle(8);

    // 20 back-to-back mixed-mode operands
    for (int i = 0; i < 20; i++)
      send(rand_data(), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    idle(8);

    // Fill, then stall the output for 7 cycles with one more operand waiting
    lat_chk = 1'b0;
    sif.out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(rand_data(), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    sif.in_valid     = 1'b1;
    sif.data_in      = 16'h1234;
    sif.shift_amount = 4'd5;
    sif.mode         = 2'b11;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("stall in_ready", 32'(sif.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    sif.out_ready = 1'b1;
    send(16'h1234, 4'd5, 2'b11);
    idle(10);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      sif.out_ready    = ($urandom_range(0, 3) != 0);
      sif.in_valid     = ($urandom_range(0, 3) != 0);
      sif.data_in      = rand_data();
      sif.shift_amount = 4'($urandom_range(0, 15));
      sif.mode         = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    sif.out_ready = 1'b1;
    idle(10);

    // Reset with three operands in flight
    lat_chk = 1'b1;
    send(16'h0123, 4'd1, 2'b00);
    send(16'h4567, 4'd2, 2'b01);
    send(16'h89AB, 4'd3, 2'b10);
    rst = 1'b1;
    q.delete();
    #1;
    check("midrst out_valid", 32'(sif.out_valid), 32'd0);
    check("midrst data_out", 32'(sif.data_out), 32'd0);
    check("midrst sat_flag", 32'(sif.sat_flag), 32'd0);
    check("midrst in_ready", 32'(sif.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(16'h0C00, 4'd4, 2'b11);
    idle(12);
    check("drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
